// File: rtl/fft_bank_xbar_ctrl.sv
// rtl/fft_bank_xbar_ctrl.sv - FFT multi-bank SRAM crossbar controller
module fft_bank_xbar_ctrl #(
    parameter int NBANK  = 4,
    parameter int NLANE  = 4,
    parameter int DW     = 52,
    parameter int AW     = 8,
    parameter int IW     = 16,
    parameter int RD_LAT = 1,
    localparam int SB    = $clog2(NBANK)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    input  logic [2*IW-1:0]       in_data,
    input  logic                  op_req,
    input  logic                  op_wr,
    input  logic [NLANE*SB-1:0]   lane_sel,
    input  logic [NLANE*AW-1:0]   lane_addr,
    input  logic [NLANE*DW-1:0]   lane_wd,
    input  logic [NLANE-1:0]      lane_wmask,
    input  logic [NBANK*DW-1:0]   bank_q,
    output logic [NBANK-1:0]      bank_cen,
    output logic [NBANK-1:0]      bank_wen,
    output logic [NBANK*AW-1:0]   bank_addr,
    output logic [NBANK*DW-1:0]   bank_d,
    output logic [NLANE*DW-1:0]   lane_q,
    output logic                  lane_q_valid,
    output logic                  load_done,
    output logic                  conflict_err
);

    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_COMP = 2'b10;
    localparam logic [1:0] MODE_R2   = 2'b11;
    localparam int         LW        = AW + SB;
    localparam int         HW        = DW / 2;

    logic [LW-1:0]       lcnt_q, lcnt_d;
    logic                load_done_q, load_done_d;
    logic                conflict_err_q, conflict_err_d;
    logic [NLANE*DW-1:0] lane_q_q, lane_q_d;
    logic                lane_q_valid_q, lane_q_valid_d;

    logic [HW-1:0]       re_ext, im_ext;
    logic [DW-1:0]       load_word;
    logic [NLANE-1:0]    lane_act;
    logic [NLANE-1:0]    lane_gnt;
    logic [NBANK-1:0]    claimed;
    logic                conflict_now;
    logic                rd_issue;

    // Read-return pipeline: valid bit, per-lane bank index and grant per stage
    logic [RD_LAT-1:0]   rd_vld_q;
    logic [NLANE*SB-1:0] rd_sel_q [RD_LAT];
    logic [NLANE-1:0]    rd_gnt_q [RD_LAT];

    assign re_ext    = HW'($signed(in_data[2*IW-1:IW]));
    assign im_ext    = HW'($signed(in_data[IW-1:0]));
    assign load_word = {re_ext, im_ext};
    assign rd_issue  = rst_n && mode[1] && op_req && !op_wr;

    // Which lanes take part in the current request (radix-2 uses lanes 0 and 1 only)
    always_comb begin
        lane_act = '0;
        for (int i = 0; i < NLANE; i++) begin
            lane_act[i] = rst_n && op_req &&
                          ((mode == MODE_COMP) || ((mode == MODE_R2) && (i < 2)));
        end
    end

    // Bank drive: load interleave or lane crossbar, lowest lane wins a contested bank
    always_comb begin : p_route
        int lb;
        lb           = 0;
        bank_cen     = '1;
        bank_wen     = '1;
        bank_addr    = '0;
        bank_d       = '0;
        lane_gnt     = '0;
        claimed      = '0;
        conflict_now = 1'b0;
        if (rst_n && (mode == MODE_LOAD) && in_valid) begin
            bank_cen[lcnt_q[SB-1:0]] = 1'b0;
            bank_wen[lcnt_q[SB-1:0]] = 1'b0;
            bank_addr[int'(lcnt_q[SB-1:0])*AW +: AW] = lcnt_q[LW-1:SB];
            for (int b = 0; b < NBANK; b++) begin
                bank_d[b*DW +: DW] = load_word;
            end
        end
        for (int i = 0; i < NLANE; i++) begin
            if (lane_act[i]) begin
                lb = int'(lane_sel[i*SB +: SB]);
                if (claimed[lb]) begin
                    conflict_now = 1'b1;
                end else begin
                    claimed[lb]             = 1'b1;
                    lane_gnt[i]             = 1'b1;
                    bank_cen[lb]            = 1'b0;
                    bank_wen[lb]            = op_wr ? ~lane_wmask[i] : 1'b1;
                    bank_addr[lb*AW +: AW]  = lane_addr[i*AW +: AW];
                    bank_d[lb*DW +: DW]     = lane_wd[i*DW +: DW];
                end
            end
        end
    end

    // Load counter and final-write pulse; the counter only runs in load mode
    always_comb begin
        lcnt_d      = lcnt_q;
        load_done_d = 1'b0;
        if (mode != MODE_LOAD) begin
            lcnt_d = '0;
        end else if (in_valid) begin
            lcnt_d      = lcnt_q + LW'(1);
            load_done_d = &lcnt_q;
        end
    end

    // Read data realignment from the selected bank back to each lane
    always_comb begin : p_return
        int rb;
        rb             = 0;
        lane_q_d       = lane_q_q;
        lane_q_valid_d = rd_vld_q[RD_LAT-1];
        if (rd_vld_q[RD_LAT-1]) begin
            for (int i = 0; i < NLANE; i++) begin
                rb = int'(rd_sel_q[RD_LAT-1][i*SB +: SB]);
                lane_q_d[i*DW +: DW] = rd_gnt_q[RD_LAT-1][i] ? bank_q[rb*DW +: DW] : '0;
            end
        end
    end

    assign conflict_err_d = conflict_err_q | conflict_now;

    // Pipeline valid bits shift every cycle regardless of mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q[0] <= rd_issue;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
            end
        end
    end

    // Lane routing payload travels alongside the valid bits
    always_ff @(posedge clk) begin
        rd_sel_q[0] <= lane_sel;
        rd_gnt_q[0] <= lane_gnt;
        for (int k = 1; k < RD_LAT; k++) begin
            rd_sel_q[k] <= rd_sel_q[k-1];
            rd_gnt_q[k] <= rd_gnt_q[k-1];
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt_q         <= '0;
            load_done_q    <= 1'b0;
            conflict_err_q <= 1'b0;
            lane_q_q       <= '0;
            lane_q_valid_q <= 1'b0;
        end else begin
            lcnt_q         <= lcnt_d;
            load_done_q    <= load_done_d;
            conflict_err_q <= conflict_err_d;
            lane_q_q       <= lane_q_d;
            lane_q_valid_q <= lane_q_valid_d;
        end
    end

    assign lane_q       = lane_q_q;
    assign lane_q_valid = lane_q_valid_q;
    assign load_done    = load_done_q;
    assign conflict_err = conflict_err_q;

endmodule

// File: tb/tb_fft_bank_xbar_ctrl.sv
// tb/tb_fft_bank_xbar_ctrl.sv - self-checking bench for fft_bank_xbar_ctrl
module tb_fft_bank_xbar_ctrl;

    localparam int NBANK  = 4;
    localparam int NLANE  = 4;
    localparam int DW     = 52;
    localparam int AW     = 8;
    localparam int IW     = 16;
    localparam int RD_LAT = 1;
    localparam int SB     = 2;
    localparam int DEPTH  = 1 << AW;

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            mode;
    logic                  in_valid;
    logic [2*IW-1:0]       in_data;
    logic                  op_req;
    logic                  op_wr;
    logic [NLANE*SB-1:0]   lane_sel;
    logic [NLANE*AW-1:0]   lane_addr;
    logic [NLANE*DW-1:0]   lane_wd;
    logic [NLANE-1:0]      lane_wmask;
    logic [NBANK*DW-1:0]   bank_q;
    logic [NBANK-1:0]      bank_cen;
    logic [NBANK-1:0]      bank_wen;
    logic [NBANK*AW-1:0]   bank_addr;
    logic [NBANK*DW-1:0]   bank_d;
    logic [NLANE*DW-1:0]   lane_q;
    logic                  lane_q_valid;
    logic                  load_done;
    logic                  conflict_err;

    fft_bank_xbar_ctrl #(
        .NBANK(NBANK), .NLANE(NLANE), .DW(DW), .AW(AW), .IW(IW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .op_req(op_req), .op_wr(op_wr), .lane_sel(lane_sel), .lane_addr(lane_addr),
        .lane_wd(lane_wd), .lane_wmask(lane_wmask), .bank_q(bank_q),
        .bank_cen(bank_cen), .bank_wen(bank_wen), .bank_addr(bank_addr), .bank_d(bank_d),
        .lane_q(lane_q), .lane_q_valid(lane_q_valid), .load_done(load_done),
        .conflict_err(conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM banks, single port, one-cycle read latency
    bit [DW-1:0] mem [NBANK][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (!bank_cen[b]) begin
                if (!bank_wen[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_d[b*DW +: DW];
                else              bank_q[b*DW +: DW] <= mem[b][bank_addr[b*AW +: AW]];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DW/2-1:0] sx(input logic [IW-1:0] v);
        return {{(DW/2-IW){v[IW-1]}}, v};
    endfunction

    function automatic int sel_of(input int i);
        return int'(lane_sel[i*SB +: SB]);
    endfunction

    function automatic bit act_of(input int i);
        return rst_n && op_req && mode[1] && ((mode == 2'b10) || (i < 2));
    endfunction

    // A lane gets its bank unless an active lower-numbered lane asked for the same bank
    function automatic logic [NLANE-1:0] grants();
        logic [NLANE-1:0] g;
        for (int i = 0; i < NLANE; i++) begin
            g[i] = act_of(i);
            for (int j = 0; j < i; j++)
                if (act_of(j) && sel_of(j) == sel_of(i)) g[i] = 1'b0;
        end
        return g;
    endfunction

    typedef struct {
        int                  due;
        logic [NLANE*DW-1:0] data;
    } ret_t;

    ret_t                pend[$];
    int                  cyc      = 0;
    int                  m_lcnt   = 0;
    logic [NLANE*DW-1:0] m_lane_q = '0;
    logic                m_valid  = 1'b0;
    logic                m_done   = 1'b0;
    logic                m_conf   = 1'b0;

    always @(posedge clk) begin
        logic [NLANE-1:0]    g;
        logic [NLANE*DW-1:0] dat;
        cyc++;
        if (!rst_n) begin
            m_lane_q = '0; m_valid = 0; m_done = 0; m_conf = 0; m_lcnt = 0;
            pend.delete();
        end else begin
            m_valid = 0;
            m_done  = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_lane_q = pend[0].data;
                m_valid  = 1;
                void'(pend.pop_front());
            end
            if (mode == 2'b01) begin
                if (in_valid) begin
                    if (m_lcnt == NBANK*DEPTH-1) m_done = 1;
                    m_lcnt = (m_lcnt + 1) % (NBANK*DEPTH);
                end
            end else begin
                m_lcnt = 0;
            end
            g = grants();
            for (int i = 0; i < NLANE; i++)
                if (act_of(i) && !g[i]) m_conf = 1;
            if (mode[1] && op_req && !op_wr) begin
                dat = '0;
                for (int i = 0; i < NLANE; i++)
                    if (g[i]) dat[i*DW +: DW] = mem[sel_of(i)][lane_addr[i*AW +: AW]];
                pend.push_back('{cyc + RD_LAT, dat});
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [NBANK-1:0]    e_cen, e_wen;
        logic [NBANK*AW-1:0] e_addr;
        logic [NBANK*DW-1:0] e_d;
        logic [NLANE-1:0]    g;
        int                  b;
        if (chk_on) begin
            e_cen = '1; e_wen = '1; e_addr = '0; e_d = '0;
            if (rst_n && mode == 2'b01 && in_valid) begin
                b = m_lcnt % NBANK;
                e_cen[b] = 0;
                e_wen[b] = 0;
                e_addr[b*AW +: AW] = AW'(m_lcnt / NBANK);
                for (int k = 0; k < NBANK; k++)
                    e_d[k*DW +: DW] = {sx(in_data[2*IW-1:IW]), sx(in_data[IW-1:0])};
            end
            g = grants();
            for (int i = 0; i < NLANE; i++) begin
                if (g[i]) begin
                    b = sel_of(i);
                    e_cen[b] = 0;
                    e_wen[b] = op_wr ? ~lane_wmask[i] : 1'b1;
                    e_addr[b*AW +: AW] = lane_addr[i*AW +: AW];
                    e_d[b*DW +: DW]    = lane_wd[i*DW +: DW];
                end
            end
            check("bank_cen", bank_cen, e_cen);
            check("bank_wen", bank_wen, e_wen);
            check("bank_addr", bank_addr, e_addr);
            check("bank_d", bank_d, e_d);
            check("lane_q", lane_q, m_lane_q);
            check("lane_q_valid", lane_q_valid, m_valid);
            check("load_done", load_done, m_done);
            check("conflict_err", conflict_err, m_conf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mode = 2'b00; in_valid = 0; in_data = '0; op_req = 0; op_wr = 0;
        lane_sel = '0; lane_addr = '0; lane_wd = '0; lane_wmask = '0;
    endtask

    task automatic lanes(input int s0, s1, s2, s3, a0, a1, a2, a3);
        lane_sel  = {SB'(s3), SB'(s2), SB'(s1), SB'(s0)};
        lane_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    int          done_cnt;
    logic [11:0] vpat;
    logic [15:0] kk;

    initial begin
        rst_n = 0;
        idle_in();
        for (int i = 0; i < NLANE; i++) lane_wd[i*DW +: DW] = DW'(1000 + i);
        repeat (3) step();
        chk_on = 1;
        check("reset_cen", bank_cen, 4'b1111);
        check("reset_valid", lane_q_valid, 1'b0);
        check("reset_conflict", conflict_err, 1'b0);

        // Read issued, then reset asserted while the request is still held
        rst_n = 1;
        mode = 2'b10; op_req = 1; op_wr = 0;
        lanes(0, 1, 2, 3, 1, 2, 3, 4);
        step();
        rst_n = 0;
        repeat (3) begin
            step();
            check("rst_hold_cen", bank_cen, 4'b1111);
        end
        rst_n = 1;
        idle_in();
        repeat (3) begin
            step();
            check("rst_no_return", lane_q_valid, 1'b0);
        end

        // Load 1024 samples {k, -k}
        done_cnt = 0;
        mode = 2'b01;
        for (int k = 0; k < NBANK*DEPTH; k++) begin
            kk = k[15:0];
            in_data  = {kk, -kk};
            in_valid = 1;
            if (k == 5) begin
                #1;
                check("load5_cen", bank_cen, 4'b1101);
                check("load5_wen", bank_wen, 4'b1101);
                check("load5_addr", bank_addr[1*AW +: AW], 8'd1);
                check("load5_d", bank_d[1*DW +: DW], {26'd5, 26'h3FFFFFB});
            end
            step();
            done_cnt += int'(load_done);
        end
        check("load_done_last", load_done, 1'b1);
        in_data = '0;
        #1;
        check("lcnt_wrap_cen", bank_cen, 4'b1110);
        check("lcnt_wrap_addr", bank_addr[AW-1:0], 8'd0);
        step();
        done_cnt += int'(load_done);
        in_valid = 0;
        mode = 2'b00;
        step();
        done_cnt += int'(load_done);
        check("load_done_count", done_cnt, 1);

        // Compute read, identity lane-to-bank mapping
        mode = 2'b10; op_req = 1; op_wr = 0;
        lanes(0, 1, 2, 3, 10, 20, 30, 40);
        #1;
        check("rd_cen", bank_cen, 4'b0000);
        check("rd_wen", bank_wen, 4'b1111);
        check("rd_addr0", bank_addr[0 +: AW], 8'd10);
        check("rd_addr3", bank_addr[3*AW +: AW], 8'd40);
        step();
        op_req = 0;
        step();
        check("rd_valid", lane_q_valid, 1'b1);
        check("rd_lane0", lane_q[0 +: DW], {26'd40, 26'h3FFFFD8});
        check("rd_lane3", lane_q[3*DW +: DW], {26'd163, 26'h3FFFF5D});
        step();
        check("rd_valid_pulse", lane_q_valid, 1'b0);

        // Compute write with reversed mapping and partial write mask
        op_req = 1; op_wr = 1; lane_wmask = 4'b0101;
        lanes(3, 2, 1, 0, 100, 101, 102, 103);
        #1;
        check("wr_wen", bank_wen, 4'b0101);
        check("wr_cen", bank_cen, 4'b0000);
        step();
        op_req = 0; op_wr = 0; lane_wmask = '0;
        step();
        check("wr_no_valid", lane_q_valid, 1'b0);

        // Radix-2: back-to-back reads, upper lanes ignored
        mode = 2'b11; op_req = 1; op_wr = 0;
        lanes(0, 1, 2, 2, 0, 1, 7, 7);
        #1;
        check("r2_cen", bank_cen, 4'b1100);
        vpat = '0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) lanes(0, 1, 2, 2, 2*c, 2*c+1, 7, 7);
            else op_req = 0;
            step();
            vpat[c] = lane_q_valid;
        end
        check("r2_valid_run", vpat, 12'b0001_1111_1110);
        check("r2_no_conflict", conflict_err, 1'b0);

        // Conflict: lanes 0 and 2 both want bank 2
        mode = 2'b10; op_req = 1; op_wr = 0;
        lanes(2, 1, 2, 3, 50, 51, 60, 61);
        #1;
        check("cf_addr2", bank_addr[2*AW +: AW], 8'd50);
        check("cf_not_yet", conflict_err, 1'b0);
        step();
        check("cf_set", conflict_err, 1'b1);
        idle_in();
        step();
        check("cf_valid", lane_q_valid, 1'b1);
        check("cf_lane2_zero", lane_q[2*DW +: DW], 52'd0);
        check("cf_lane0", lane_q[0 +: DW], {26'd202, 26'h3FFFF36});
        repeat (100) step();
        check("cf_sticky", conflict_err, 1'b1);

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
